seq_divider: RTL and testbench

- Parametrised sequential long-division unit. Successor to the team's fixed unsigned divider.
- Adds a signed/unsigned mode, a busy output, signed-overflow detection and a defined division-by-zero result.
- Shift-subtract (restoring) datapath: one quotient bit per cycle.
- Sits beside the ALU as a multi-cycle functional unit, driven by a start/done handshake.

---
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, signed/unsigned, start/done handshake.
// Optional build macro SEQ_DIV_EARLY_TERM_EN: finish early when |dividend| < |divisor|.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH-1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;    // dividend magnitude, quotient bits shift in at the LSB
  logic [WIDTH-1:0] rem_q;    // partial remainder magnitude
  logic [WIDTH-1:0] dsr_q;    // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic             err_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             ovf_hit;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  assign dvd_mag = mag_of(dividend, is_signed);
  assign dsr_mag = mag_of(divisor, is_signed);
  assign ovf_hit = is_signed && (dividend == MOST_NEG) && (divisor == ONES);

`ifdef SEQ_DIV_EARLY_TERM_EN
  logic skip_q;
  logic early_hit;
  assign early_hit = (dvd_mag < dsr_mag);
`endif

  // One shift-subtract step; the partial remainder is always below the divisor,
  // so the WIDTH+1-bit difference is negative exactly when its top bit is set.
  always_comb begin
    shift_s = {rem_q, dvd_q[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dsr_q};
    if (diff_s[WIDTH]) begin
      rem_d = shift_s[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff_s[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      dvd_q     <= ZERO;
      rem_q     <= ZERO;
      dsr_q     <= ZERO;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      quotient  <= ZERO;
      remainder <= ZERO;
`ifdef SEQ_DIV_EARLY_TERM_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_q <= CNT_INIT;
            dsr_q <= dsr_mag;
            if (divisor == ZERO) begin
              // FIX passes these through untouched: quotient all ones, remainder = dividend
              state_q <= S_FIX;
              dvd_q   <= ONES;
              rem_q   <= dividend;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ITER;
              dvd_q   <= dvd_mag;
              rem_q   <= ZERO;
              q_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_q <= is_signed & dividend[WIDTH-1];
              err_q   <= ovf_hit;
`ifdef SEQ_DIV_EARLY_TERM_EN
              skip_q  <= early_hit;
              if (early_hit) begin
                dvd_q <= ZERO;
                rem_q <= dvd_mag;
                cnt_q <= CNT_ZERO;
              end
`endif
            end
          end
        end
        S_ITER: begin
`ifdef SEQ_DIV_EARLY_TERM_EN
          if (!skip_q) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
          end
`else
          rem_q <= rem_d;
          dvd_q <= dvd_d;
`endif
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_FIX: begin
          quotient  <= q_neg_q ? negate(dvd_q) : dvd_q;
          remainder <= r_neg_q ? negate(rem_q) : rem_q;
          error     <= err_q;
          done      <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_seq_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start, is_signed;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic busy, done, error;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .error(error), .quotient(quotient), .remainder(remainder)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] absval(input logic [W-1:0] v, input logic sg);
    return (sg && v[W-1]) ? -v : v;
  endfunction

  // Reference: SV integer division truncates toward zero, % follows the dividend sign.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    e = 1'b0;
    lat = W + 1;
    if (b == '0) begin
      q = '1; r = a; e = 1'b1; lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; e = 1'b1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
`ifdef SEQ_DIV_EARLY_TERM_EN
    if (b != '0 && absval(a, sg) < absval(b, sg)) lat = 2;
`endif
  endfunction

  // poke_at: cycle after E0 at which a stray 9/3 start pulse is driven (0 = none).
  // hold: keep start high so the next request is accepted right after DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input string tag, input int poke_at, input bit hold);
    logic [W-1:0] eq, er;
    logic ee;
    int lat, got;
    ref_div(a, b, sg, eq, er, ee, lat);
    @(negedge clk);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    end
    check_bit({tag, ".busy"}, busy, 1'b1);
    check({tag, ".q_hold"}, quotient, prev_q);
    check({tag, ".r_hold"}, remainder, prev_r);
    got = 0;
    for (int k = 1; k <= W + 10; k++) begin
      @(posedge clk); #1;
      if (poke_at > 0 && k == poke_at) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
      end else if (!hold) begin
        start = 1'b0;
      end
      if (done) begin
        got = k;
        break;
      end
    end
    check({tag, ".latency"}, got, lat);
    if (got != 0) begin
      check({tag, ".quot"}, quotient, eq);
      check({tag, ".rem"}, remainder, er);
      check_bit({tag, ".err"}, error, ee);
      prev_q = eq;
      prev_r = er;
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check_bit({tag, ".done_drop"}, done, 1'b0);
    check_bit({tag, ".busy_drop"}, busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int sel, got, dones;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst.busy", busy, 1'b0);
    check_bit("rst.done", done, 1'b0);
    check_bit("rst.err", error, 1'b0);
    check("rst.quot", quotient, '0);
    check("rst.rem", remainder, '0);
    @(negedge clk) reset = 1'b1;

    do_op(32'd100, 32'd7, 1'b0, "u100_7", 0, 1'b0);
    do_op(-32'd100, 32'd7, 1'b1, "sm100_7", 0, 1'b0);
    do_op(32'd100, -32'd7, 1'b1, "s100_m7", 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd0, 1'b0, "udivz", 0, 1'b0);
    do_op(32'h8000_0005, 32'd0, 1'b1, "sdivz", 0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sovf", 0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_noovf", 0, 1'b0);
    do_op(32'd5, 32'd9, 1'b0, "u5_9", 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1", 0, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b1, "smin_1", 0, 1'b0);
    do_op(32'd50, 32'd5, 1'b0, "ign_iter", 10, 1'b0);
    do_op(32'd77, 32'd8, 1'b0, "ign_done", W + 1, 1'b0);

    // start held high: second operation accepted on the first IDLE cycle
    do_op(32'd12, 32'd4, 1'b0, "hold1", 0, 1'b1);
    @(posedge clk); #1;
    check_bit("hold2.busy", busy, 1'b1);
    start = 1'b0;
    got = 0;
    for (int k = 1; k <= W + 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got = k;
        break;
      end
    end
    check("hold2.latency", got, W + 1);
    check("hold2.quot", quotient, 32'd3);
    check("hold2.rem", remainder, 32'd0);
    prev_q = 32'd3; prev_r = 32'd0;
    @(posedge clk); #1;

    // reset mid-operation aborts with no done pulse
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_bit("abort.busy", busy, 1'b0);
    check_bit("abort.done", done, 1'b0);
    check_bit("abort.err", error, 1'b0);
    check("abort.quot", quotient, '0);
    check("abort.rem", remainder, '0);
    prev_q = '0; prev_r = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < W + 5; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.no_done", dones, 0);
    do_op(32'd9, 32'd3, 1'b0, "post_rst", 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = (sel == 9) ? 32'h8000_0000 : $urandom;
      if (sel == 0) b = '0;
      else if (sel < 4) b = $urandom_range(1, 20);
      else if (sel < 6) b = -$urandom_range(1, 20);
      else if (sel == 9) b = 32'hFFFF_FFFF;
      else b = $urandom;
      do_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
